uart_comm: RTL and testbench

- Host-side link stage directly upstream of the digital core.
- Receives 8N1 UART bytes from the HOST and assembles every three bytes into a 24-bit command, MSB first, presented with a cmd_rdy flag.
- Serialises single-byte responses from the core back to the HOST.
- Contains its own baud generators for RX and TX; no external UART cell.

---
 rtl/uart_comm.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_comm.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_comm.sv
// Host-side UART link: 8N1 receiver that packs three bytes into a 24-bit command,
// plus a one-byte response transmitter. Optional inter-byte timeout: CMD_TIMEOUT_EN.
module uart_comm #(
    parameter int BAUD_DIV     = 434,
    parameter int TIMEOUT_BITS = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp_data,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic TX_IDLE = 1'b0;
    localparam logic TX_XMIT = 1'b1;

    if (BAUD_DIV < 4 || TIMEOUT_BITS < 1) begin : g_bad_cfg
        $error("uart_comm: BAUD_DIV must be >= 4 and TIMEOUT_BITS >= 1");
    end

    logic          rx_s1, rx_s2, rx_s3;
    logic [1:0]    rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bits;
    logic [7:0]    rx_shift;
    logic          rx_rdy;
    logic          start_det;

    logic [1:0]    byte_cnt;
    logic [15:0]   hold;
    logic          cmd_set;
    logic          to_hit;

    logic          tx_state;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_left;
    logic [8:0]    tx_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign start_det = (rx_state == RX_IDLE) && rx_s3 && !rx_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
            rx_rdy   <= 1'b0;
        end else begin
            rx_rdy <= 1'b0;
            unique case (rx_state)
                RX_IDLE: begin
                    if (start_det) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_M1) begin
                        rx_cnt   <= '0;
                        rx_bits  <= '0;
                        // line back high at mid start bit means a glitch
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == FULL_M1) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_bits  <= rx_bits + 1'b1;
                        if (rx_bits == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == FULL_M1) begin
                        rx_cnt   <= '0;
                        rx_rdy   <= rx_s2;
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

`ifdef CMD_TIMEOUT_EN
    localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
    localparam int TW = $clog2(TO_LIMIT + 1);

    logic [TW-1:0] to_cnt;
    logic          to_run;

    assign to_run = (byte_cnt != 2'd0) && (rx_state == RX_IDLE) && !start_det;
    assign to_hit = to_run && (to_cnt == TW'(TO_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (!to_run || to_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    assign cmd_set = rx_rdy && (byte_cnt == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            hold     <= '0;
            cmd      <= '0;
            cmd_rdy  <= 1'b0;
        end else begin
            if (rx_rdy) begin
                unique case (byte_cnt)
                    2'd0: begin
                        hold[15:8] <= rx_shift;
                        byte_cnt   <= 2'd1;
                    end
                    2'd1: begin
                        hold[7:0] <= rx_shift;
                        byte_cnt  <= 2'd2;
                    end
                    default: begin
                        cmd      <= {hold, rx_shift};
                        byte_cnt <= 2'd0;
                    end
                endcase
            end else if (to_hit) begin
                byte_cnt <= 2'd0;
                hold     <= '0;
            end
            // a completing command beats any clear in the same cycle
            if (cmd_set) begin
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy || start_det) begin
                cmd_rdy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_left   <= '0;
            tx_shift  <= '0;
            TX        <= 1'b1;
            resp_sent <= 1'b0;
        end else begin
            resp_sent <= 1'b0;
            unique case (tx_state)
                TX_IDLE: begin
                    // no restart on the resp_sent cycle itself
                    if (send_resp && !resp_sent) begin
                        tx_shift <= {1'b1, resp_data};
                        tx_left  <= 4'd9;
                        tx_cnt   <= '0;
                        TX       <= 1'b0;
                        tx_state <= TX_XMIT;
                    end
                end
                TX_XMIT: begin
                    if (tx_cnt == FULL_M1) begin
                        tx_cnt <= '0;
                        if (tx_left == 4'd0) begin
                            resp_sent <= 1'b1;
                            tx_state  <= TX_IDLE;
                        end else begin
                            TX       <= tx_shift[0];
                            tx_shift <= {1'b1, tx_shift[8:1]};
                            tx_left  <= tx_left - 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_comm.sv
// Bench for uart_comm: directed UART frames and responses checked against
// a byte-level command model and a bit-time TX model.
module tb_uart_comm;

    localparam int BD  = 8;
    localparam int TOB = 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp_data = 8'h00;
    logic        send_resp = 1'b0;
    logic        resp_sent;

    uart_comm #(.BAUD_DIV(BD), .TIMEOUT_BITS(TOB)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .RX(RX),
        .TX(TX),
        .cmd(cmd),
        .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .resp_data(resp_data),
        .send_resp(send_resp),
        .resp_sent(resp_sent)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // TX model: cycles since a response was accepted, 1000 = idle
    int         m_t = 1000;
    logic [9:0] m_frame = 10'h3FF;

    // command model, written only by the stimulus tasks
    logic [23:0] m_cmd = 24'h0;
    logic        m_rdy = 1'b0;
    int          m_cnt = 0;
    logic [15:0] m_hold = 16'h0;
    int          last_cyc = 0;
    bit          busy = 1'b1;

    logic        exp_tx;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t <= 1000;
        end else if (send_resp && m_t > 80) begin
            m_t     <= 0;
            m_frame <= {1'b1, resp_data, 1'b0};
        end else if (m_t < 1000) begin
            m_t <= m_t + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_tx", TX, 1);
            chk("rst_cmd", cmd, 0);
            chk("rst_cmd_rdy", cmd_rdy, 0);
            chk("rst_resp_sent", resp_sent, 0);
        end else begin
            exp_tx = (m_t < 80) ? m_frame[m_t/8] : 1'b1;
            chk("tx_bit", TX, exp_tx);
            chk("resp_sent", resp_sent, (m_t == 80));
            if (!busy) begin
                chk("cmd", cmd, m_cmd);
                chk("cmd_rdy", cmd_rdy, m_rdy);
            end
        end
    end

    task automatic model_byte(input logic [7:0] b);
        if (m_cnt == 0) begin
            m_hold[15:8] = b;
            m_cnt = 1;
        end else if (m_cnt == 1) begin
            m_hold[7:0] = b;
            m_cnt = 2;
        end else begin
            m_cmd = {m_hold, b};
            m_rdy = 1'b1;
            m_cnt = 0;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input bit chk_drop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        busy = 1'b1;
`ifdef CMD_TIMEOUT_EN
        if (m_cnt != 0 && (cyc - last_cyc) >= TOB * BD) m_cnt = 0;
`endif
        for (int b = 0; b < 10; b++) begin
            @(negedge clk);
            RX = f[b];
            if (b == 0 && chk_drop) begin
                repeat (5) @(negedge clk);
                chk("rdy_drop_on_start", cmd_rdy, 0);
                repeat (BD - 6) @(negedge clk);
            end else begin
                repeat (BD - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        RX = 1'b1;
        repeat (4) @(negedge clk);
        m_rdy = 1'b0;
        if (stop) begin
            model_byte(d);
            last_cyc = cyc;
        end
        busy = 1'b0;
    endtask

    task automatic send_glitch();
        busy = 1'b1;
        @(negedge clk);
        RX = 1'b0;
        repeat (2) @(negedge clk);
        RX = 1'b1;
        repeat (12) @(negedge clk);
        m_rdy = 1'b0;
        busy = 1'b0;
    endtask

    task automatic pulse_clr(input logic [23:0] keep);
        busy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        chk("clr_next_cycle", cmd_rdy, 0);
        chk("clr_keeps_cmd", cmd, keep);
        m_rdy = 1'b0;
        busy = 1'b0;
    endtask

    logic lit [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                       1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        busy = 1'b0;
        chk("reset_cmd_lit", cmd, 24'h0);
        chk("reset_tx_lit", TX, 1);

        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h23, 1'b1, 1'b0);
        send_frame(8'h45, 1'b1, 1'b0);
        chk("cmd_012345", cmd, 24'h012345);
        chk("rdy_012345", cmd_rdy, 1);
        pulse_clr(24'h012345);

        send_frame(8'h10, 1'b1, 1'b0);
        send_frame(8'h20, 1'b1, 1'b0);
        send_frame(8'h30, 1'b1, 1'b0);
        chk("rdy_before_drop", cmd_rdy, 1);
        send_frame(8'hAA, 1'b1, 1'b1);
        send_frame(8'hBB, 1'b1, 1'b0);
        send_frame(8'hCC, 1'b1, 1'b0);
        chk("cmd_aabbcc", cmd, 24'hAABBCC);

        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        chk("cmd_framing", cmd, 24'h112233);
        send_glitch();
        send_frame(8'h44, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'h66, 1'b1, 1'b0);
        chk("cmd_after_glitch", cmd, 24'h445566);

        @(negedge clk);
        resp_data = 8'hA5;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        for (int t = 0; t <= 81; t++) begin
            if (t < 80 && (t % 8) == 4) chk("tx_a5_lit", TX, lit[t/8]);
            if (t == 40) begin
                resp_data = 8'h3C;
                send_resp = 1'b1;
            end
            if (t == 41) send_resp = 1'b0;
            if (t == 79) chk("sent_early_lit", resp_sent, 0);
            if (t == 80) begin
                chk("sent_lit", resp_sent, 1);
                send_resp = 1'b1;
            end
            if (t == 81) begin
                send_resp = 1'b0;
                chk("no_restart_lit", TX, 1);
                chk("sent_once_lit", resp_sent, 0);
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        resp_data = 8'h3C;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        chk("second_start_lit", TX, 0);
        repeat (90) @(negedge clk);

        send_frame(8'h77, 1'b1, 1'b0);
        busy = 1'b1;
        @(negedge clk);
        resp_data = 8'h81;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        RX = 1'b0;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_tx_lit", TX, 1);
        chk("midrst_rdy_lit", cmd_rdy, 0);
        RX = 1'b1;
        m_cnt = 0;
        m_cmd = 24'h0;
        m_rdy = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        busy = 1'b0;
        send_frame(8'h0F, 1'b1, 1'b0);
        send_frame(8'h0E, 1'b1, 1'b0);
        send_frame(8'h0D, 1'b1, 1'b0);
        chk("cmd_after_reset", cmd, 24'h0F0E0D);
        chk("rdy_after_reset", cmd_rdy, 1);

        send_frame(8'h01, 1'b1, 1'b0);
        repeat (TOB * BD) @(negedge clk);
        send_frame(8'h02, 1'b1, 1'b0);
        send_frame(8'h03, 1'b1, 1'b0);
        send_frame(8'h04, 1'b1, 1'b0);
`ifdef CMD_TIMEOUT_EN
        chk("cmd_timeout", cmd, 24'h020304);
`else
        chk("cmd_no_timeout", cmd, 24'h010203);
        send_frame(8'h05, 1'b1, 1'b0);
        send_frame(8'h06, 1'b1, 1'b0);
        chk("cmd_held_byte", cmd, 24'h040506);
`endif
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
